// File: rtl/set_pkg.sv
// Shared types and constants for the SET engine host.
// Mode encodings, field widths, host FSM states and the command bundle.
package set_pkg;

  localparam logic [1:0] MODE_A   = 2'd0;
  localparam logic [1:0] MODE_AND = 2'd1;
  localparam logic [1:0] MODE_XOR = 2'd2;

  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int COUNT_W   = 8;

  // Widest tag a host instance may use; the command bundle carries
  // this many bits and each instance uses only its low TAG_W bits.
  localparam int TAG_MAX_W = 16;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    logic [1:0]           mode;
    logic [TAG_MAX_W-1:0] tag;
  } cmd_t;

  function automatic cmd_t pack_cmd(
    input logic [CENTRAL_W-1:0] central,
    input logic [RADIUS_W-1:0]  radius,
    input logic [1:0]           mode,
    input logic [TAG_MAX_W-1:0] tag
  );
    cmd_t c;
    c.central = central;
    c.radius  = radius;
    c.mode    = mode;
    c.tag     = tag;
    return c;
  endfunction

endpackage

// File: rtl/set_cmd_fifo.sv
// Synchronous command FIFO holding cmd_t entries for the SET host.
// Ports: clk/rst, push_i+data_i, pop_i, data_o (head), full_o, empty_o.
module set_cmd_fifo
  import set_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  cmd_t data_i,
  input  logic pop_i,
  output cmd_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  cmd_t mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty differ
  // only in that bit and wrap-around needs no special casing.
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        push_ok;
  logic        pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  assign data_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + (AW+1)'(1);
    if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/set_host.sv
// Command initiator for one SET engine: queues tagged queries, issues
// them one at a time, applies a watchdog and returns tagged counts.
// Ports: cmd_* (upstream valid/ready), en/central/radius/mode/busy/
// valid/candidate (engine), res_* (downstream valid/ready), idle.
module set_host
  import set_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 80,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CENTRAL_W-1:0] cmd_central,
  input  logic [RADIUS_W-1:0]  cmd_radius,
  input  logic [1:0]           cmd_mode,
  input  logic [TAG_W-1:0]     cmd_tag,
  output logic                 en,
  output logic [CENTRAL_W-1:0] central,
  output logic [RADIUS_W-1:0]  radius,
  output logic [1:0]           mode,
  input  logic                 busy,
  input  logic                 valid,
  input  logic [COUNT_W-1:0]   candidate,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [COUNT_W-1:0]   res_candidate,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 res_timeout,
  output logic                 idle
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  state_t               state_q, state_d;
  logic                 en_q, en_d;
  logic [CENTRAL_W-1:0] central_q, central_d;
  logic [RADIUS_W-1:0]  radius_q, radius_d;
  logic [1:0]           mode_q, mode_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 res_valid_q, res_valid_d;
  logic [COUNT_W-1:0]   res_cand_q, res_cand_d;
  logic [TAG_W-1:0]     res_tag_q, res_tag_d;
  logic                 res_tout_q, res_tout_d;

  cmd_t push_cmd;
  cmd_t head;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic can_issue;
  logic unused_tag;

  assign push_cmd = pack_cmd(cmd_central, cmd_radius, cmd_mode,
                             TAG_MAX_W'(cmd_tag));

  assign fifo_push = cmd_valid & ~fifo_full;
  assign cmd_ready = ~fifo_full;

  // Issue only when the engine is free and the result slot is free
  // or being emptied this cycle, so a result is never overwritten.
  assign can_issue = (state_q == IDLE) & ~fifo_empty & ~busy &
                     (~res_valid_q | res_ready);

  set_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (push_cmd),
    .pop_i   (can_issue),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Only the low TAG_W bits of the stored tag are meaningful.
  assign unused_tag = ^head.tag;

  always_comb begin
    state_d     = state_q;
    en_d        = 1'b0;
    central_d   = central_q;
    radius_d    = radius_q;
    mode_d      = mode_q;
    tag_d       = tag_q;
    timer_d     = timer_q;
    res_valid_d = res_valid_q;
    res_cand_d  = res_cand_q;
    res_tag_d   = res_tag_q;
    res_tout_d  = res_tout_q;

    if (res_ready) res_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A late or spurious engine valid is ignored here.
        if (can_issue) begin
          central_d = head.central;
          radius_d  = head.radius;
          mode_d    = head.mode;
          tag_d     = head.tag[TAG_W-1:0];
          en_d      = 1'b1;
          timer_d   = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (timer_q != TMR_MAX) timer_d = timer_q + TMR_W'(1);
        // A real result beats the watchdog in the same cycle.
        if (valid) begin
          res_cand_d  = candidate;
          res_tag_d   = tag_q;
          res_tout_d  = 1'b0;
          res_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (timer_q == TMR_LAST) begin
          res_cand_d  = '0;
          res_tag_d   = tag_q;
          res_tout_d  = 1'b1;
          res_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      central_q   <= '0;
      radius_q    <= '0;
      mode_q      <= '0;
      tag_q       <= '0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      res_cand_q  <= '0;
      res_tag_q   <= '0;
      res_tout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      central_q   <= central_d;
      radius_q    <= radius_d;
      mode_q      <= mode_d;
      tag_q       <= tag_d;
      timer_q     <= timer_d;
      res_valid_q <= res_valid_d;
      res_cand_q  <= res_cand_d;
      res_tag_q   <= res_tag_d;
      res_tout_q  <= res_tout_d;
    end
  end

  assign en            = en_q;
  assign central       = central_q;
  assign radius        = radius_q;
  assign mode          = mode_q;
  assign res_valid     = res_valid_q;
  assign res_candidate = res_cand_q;
  assign res_tag       = res_tag_q;
  assign res_timeout   = res_tout_q;
  assign idle          = (state_q == IDLE) & fifo_empty & ~res_valid_q;

endmodule

// File: tb/tb_set_host.sv
// Directed self-checking bench for set_host with a behavioural SET
// engine model (64 busy cycles, then a one-cycle valid pulse).
module tb_set_host;
  import set_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_central = '0;
  logic [11:0] cmd_radius = '0;
  logic [1:0]  cmd_mode = '0;
  logic [3:0]  cmd_tag = '0;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy;
  logic        valid;
  logic [7:0]  candidate;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_candidate;
  logic [3:0]  res_tag;
  logic        res_timeout;
  logic        idle;

  int checks = 0;
  int errs = 0;
  int en_cnt = 0;

  logic        hang = 1'b0;
  logic        inject = 1'b0;
  logic [5:0]  ecnt;
  logic [23:0] e_c;
  logic [11:0] e_r;
  logic [1:0]  e_m;

  set_host #(
    .DEPTH   (4),
    .TIMEOUT (80),
    .TAG_W   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_central   (cmd_central),
    .cmd_radius    (cmd_radius),
    .cmd_mode      (cmd_mode),
    .cmd_tag       (cmd_tag),
    .en            (en),
    .central       (central),
    .radius        (radius),
    .mode          (mode),
    .busy          (busy),
    .valid         (valid),
    .candidate     (candidate),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_candidate (res_candidate),
    .res_tag       (res_tag),
    .res_timeout   (res_timeout),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] set_count(
    input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int x1 = int'(c[23:20]);
    int y1 = int'(c[19:16]);
    int x2 = int'(c[15:12]);
    int y2 = int'(c[11:8]);
    int r1 = int'(r[11:8]);
    int r2 = int'(r[7:4]);
    int n = 0;
    bit a, b;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a = ((x-x1)*(x-x1) + (y-y1)*(y-y1)) <= r1*r1;
        b = ((x-x2)*(x-x2) + (y-y2)*(y-y2)) <= r2*r2;
        case (m)
          2'd0: n += int'(a);
          2'd1: n += int'(a && b);
          2'd2: n += int'(a ^ b);
          default: n += 0;
        endcase
      end
    end
    return 8'(n);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      valid     <= 1'b0;
      ecnt      <= '0;
      candidate <= '0;
    end else begin
      valid <= inject;
      if (busy) begin
        ecnt <= ecnt + 6'd1;
        if (ecnt == 6'd63) begin
          busy      <= 1'b0;
          valid     <= 1'b1;
          candidate <= set_count(e_c, e_r, e_m);
        end
      end else if (en && !hang) begin
        busy <= 1'b1;
        ecnt <= '0;
        e_c  <= central;
        e_r  <= radius;
        e_m  <= mode;
      end
    end
  end

  always @(posedge clk) if (en === 1'b1) en_cnt <= en_cnt + 1;

  task automatic push(input logic [23:0] c, input logic [11:0] r,
                      input logic [1:0] m, input logic [3:0] t);
    int n = 0;
    cmd_valid   = 1'b1;
    cmd_central = c;
    cmd_radius  = r;
    cmd_mode    = m;
    cmd_tag     = t;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errs++;
      $display("FAIL push_stall tag=%0d cmd_ready=0 required 1", t);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string nm, output int lat,
                          output int en_len);
    int n = 0;
    int en_at = -1;
    en_len = 0;
    while (!res_valid && n < 400) begin
      if (en) begin
        if (en_at < 0) en_at = n;
        en_len++;
      end
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      checks++; errs++;
      $display("FAIL %s_wait res_valid=0 after %0d cycles required 1",
               nm, n);
    end
    lat = (en_at < 0) ? -1 : n - en_at;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({en, central, radius, mode} !== 39'd0) begin
      errs++;
      $display("FAIL reset_issue got en=%b c=%h r=%h m=%0d required 0",
               en, central, radius, mode);
    end
    checks++;
    if ({res_valid, res_candidate, res_tag, res_timeout} !== 14'd0) begin
      errs++;
      $display("FAIL reset_res got v=%b c=%0d t=%0d to=%b required 0",
               res_valid, res_candidate, res_tag, res_timeout);
    end
    checks++;
    if (cmd_ready !== 1'b1 || idle !== 1'b1) begin
      errs++;
      $display("FAIL reset_flags got ready=%b idle=%b required 1 1",
               cmd_ready, idle);
    end
  endtask

  task automatic test_single();
    int lat, len;
    res_ready = 1'b0;
    push(24'h440000, 12'h200, MODE_A, 4'h5);
    wait_res("single", lat, len);
    checks++;
    if (len !== 1) begin
      errs++;
      $display("FAIL single_en_len got %0d required 1", len);
    end
    checks++;
    if (lat !== 66) begin
      errs++;
      $display("FAIL single_latency got %0d required 66", lat);
    end
    checks++;
    if (res_candidate !== 8'd13 || res_timeout !== 1'b0 ||
        res_tag !== 4'h5) begin
      errs++;
      $display("FAIL single_res got c=%0d to=%b t=%0d required 13 0 5",
               res_candidate, res_timeout, res_tag);
    end
    checks++;
    if (central !== 24'h440000 || radius !== 12'h200 || mode !== 2'd0) begin
      errs++;
      $display("FAIL single_fields got %h %h %0d required 440000 200 0",
               central, radius, mode);
    end
    accept();
    checks++;
    if (res_valid !== 1'b0 || idle !== 1'b1) begin
      errs++;
      $display("FAIL single_accept got v=%b idle=%b required 0 1",
               res_valid, idle);
    end
  endtask

  task automatic test_identical();
    logic [1:0] md [3];
    logic [7:0] ex [3];
    int lat, len;
    md = '{2'd1, 2'd2, 2'd3};
    ex = '{8'd13, 8'd0, 8'd0};
    for (int i = 0; i < 3; i++) begin
      push(24'h444400, 12'h220, md[i], 4'(10 + i));
      wait_res("ident", lat, len);
      checks++;
      if (res_candidate !== ex[i] || res_tag !== 4'(10 + i) ||
          mode !== md[i]) begin
        errs++;
        $display("FAIL ident_m%0d got c=%0d t=%0d m=%0d required %0d %0d %0d",
                 md[i], res_candidate, res_tag, mode, ex[i], 10 + i, md[i]);
      end
      accept();
    end
  endtask

  task automatic test_backpressure();
    int lat, len, e0, bad;
    res_ready = 1'b0;
    e0 = en_cnt;
    push(24'h444400, 12'h220, MODE_AND, 4'h7);
    push(24'h440000, 12'h300, MODE_A, 4'h8);
    wait_res("bp1", lat, len);
    checks++;
    if (res_candidate !== 8'd13 || res_tag !== 4'h7) begin
      errs++;
      $display("FAIL bp_first got c=%0d t=%0d required 13 7",
               res_candidate, res_tag);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (en || !res_valid || res_candidate != 8'd13 ||
          res_tag != 4'h7 || res_timeout) bad++;
    end
    checks++;
    if (bad !== 0 || en_cnt - e0 !== 1) begin
      errs++;
      $display("FAIL bp_hold got bad=%0d ens=%0d required 0 1",
               bad, en_cnt - e0);
    end
    accept();
    checks++;
    if (res_valid !== 1'b0 || en !== 1'b1) begin
      errs++;
      $display("FAIL bp_release got v=%b en=%b required 0 1",
               res_valid, en);
    end
    wait_res("bp2", lat, len);
    checks++;
    if (res_candidate !== 8'd29 || res_tag !== 4'h8 || lat !== 66) begin
      errs++;
      $display("FAIL bp_second got c=%0d t=%0d lat=%0d required 29 8 66",
               res_candidate, res_tag, lat);
    end
    accept();
  endtask

  task automatic test_burst();
    logic [3:0] tags [5];
    logic [7:0] cands [5];
    int e0, got, n, last, gap_bad;
    res_ready = 1'b1;
    e0 = en_cnt;
    for (int i = 0; i < 5; i++) push(24'h440000, 12'h200, MODE_A, 4'(i));
    checks++;
    if (cmd_ready !== 1'b0) begin
      errs++;
      $display("FAIL burst_full got cmd_ready=%b required 0", cmd_ready);
    end
    got = 0; n = 0; last = -1; gap_bad = 0;
    while (got < 5 && n < 1000) begin
      @(negedge clk);
      n++;
      if (en) begin
        if (last >= 0 && n - last != 67) gap_bad++;
        last = n;
      end
      if (res_valid) begin
        tags[got]  = res_tag;
        cands[got] = res_candidate;
        got++;
      end
    end
    checks++;
    if (got !== 5) begin
      errs++;
      $display("FAIL burst_count got %0d results required 5", got);
    end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (tags[i] !== 4'(i) || cands[i] !== 8'd13) begin
        errs++;
        $display("FAIL burst_res%0d got t=%0d c=%0d required %0d 13",
                 i, tags[i], cands[i], i);
      end
    end
    checks++;
    if (gap_bad !== 0) begin
      errs++;
      $display("FAIL back_to_back got %0d bad en gaps required 0", gap_bad);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (en_cnt - e0 !== 5 || idle !== 1'b1) begin
      errs++;
      $display("FAIL burst_en got ens=%0d idle=%b required 5 1",
               en_cnt - e0, idle);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int lat, len;
    hang = 1'b1;
    res_ready = 1'b0;
    push(24'h440000, 12'h200, MODE_A, 4'h9);
    wait_res("timeout", lat, len);
    checks++;
    if (lat !== 80) begin
      errs++;
      $display("FAIL timeout_latency got %0d required 80", lat);
    end
    checks++;
    if (res_timeout !== 1'b1 || res_candidate !== 8'd0 ||
        res_tag !== 4'h9) begin
      errs++;
      $display("FAIL timeout_res got to=%b c=%0d t=%0d required 1 0 9",
               res_timeout, res_candidate, res_tag);
    end
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_timeout !== 1'b1 ||
        res_candidate !== 8'd0) begin
      errs++;
      $display("FAIL stray_held got v=%b to=%b c=%0d required 1 1 0",
               res_valid, res_timeout, res_candidate);
    end
    accept();
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || idle !== 1'b1) begin
      errs++;
      $display("FAIL stray_idle got v=%b idle=%b required 0 1",
               res_valid, idle);
    end
    hang = 1'b0;
  endtask

  task automatic test_reset_wait();
    int e0, seen;
    res_ready = 1'b1;
    e0 = en_cnt;
    push(24'h440000, 12'h200, MODE_A, 4'h1);
    push(24'h440000, 12'h200, MODE_A, 4'h2);
    push(24'h440000, 12'h200, MODE_A, 4'h3);
    repeat (18) @(negedge clk);
    checks++;
    if (en_cnt - e0 !== 1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL rstw_inflight got ens=%0d busy=%b required 1 1",
               en_cnt - e0, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({en, central, radius, mode, res_valid, res_candidate,
         res_tag, res_timeout} !== 53'd0) begin
      errs++;
      $display("FAIL rstw_outputs got en=%b c=%h r=%h m=%0d v=%b rc=%0d t=%0d to=%b required 0",
               en, central, radius, mode, res_valid, res_candidate,
               res_tag, res_timeout);
    end
    checks++;
    if (idle !== 1'b1 || cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL rstw_flags got idle=%b ready=%b required 1 1",
               idle, cmd_ready);
    end
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (res_valid || en) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errs++;
      $display("FAIL rstw_dropped got %0d active cycles required 0", seen);
    end
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_identical();
    test_backpressure();
    test_burst();
    test_timeout();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule

// File: doc/set_host.md
# set_host

Command initiator for the `SET` circle-counting engine. It accepts tagged set-query commands from an upstream controller into a small FIFO and drives the engine's `en`/`central`/`radius`/`mode` inputs. It waits for the engine's `valid` pulse, applies a watchdog, and presents each count with its tag on a ready/valid result port. It sits between system control and one `SET` instance, sharing that instance's clock and reset.

## Interface
- `DEPTH`, default 4: command FIFO entries (power of two, ≥2).
- `TIMEOUT`, default 80: WAIT cycles before declaring the engine hung.
- `TAG_W`, default 4: command tag width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  upstream command present.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_central`  in  24  {x1,y1,x2,y2,8'b0}, one nibble per coordinate.
- `cmd_radius`  in  12  {r1,r2,4'b0}.
- `cmd_mode`  in  2  0 = in A, 1 = A∧B, 2 = A⊕B; 3 is passed through unchanged.
- `cmd_tag`  in  TAG_W  returned with the result.
- `en`  out  1  one-cycle issue pulse to the engine.
- `central`, `radius`, `mode`  out  24/12/2  issued fields, held until the next issue.
- `busy`  in  1  engine busy.
- `valid`  in  1  engine result pulse.
- `candidate`  in  8  engine count.
- `res_valid`  out  1  result held.
- `res_ready`  in  1  downstream accepts.
- `res_candidate`  out  8  count; 0 on timeout.
- `res_tag`  out  TAG_W  tag of the completed command.
- `res_timeout`  out  1  result produced by the watchdog.
- `idle`  out  1  state IDLE, FIFO empty and `res_valid`=0.

## Operation
- FIFO push on `cmd_valid & cmd_ready`.
  - `cmd_ready` = !full, with no pass-through when full.
  - A push into an empty FIFO is not poppable until the next cycle.
- FSM has two states, IDLE and WAIT. One command is outstanding at most.
- IDLE → WAIT when all of the following hold:
  - the FIFO is non-empty;
  - `busy`=0;
  - `res_valid`=0 or `res_ready`=1.
- On that edge:
  - pop the FIFO head;
  - register its fields onto `central`/`radius`/`mode` and its tag internally;
  - set `en`<=1;
  - clear the timer.
- In WAIT:
  - `en`<=0 on the first edge, so `en` is high for exactly one cycle;
  - the timer increments each cycle.
  - On `valid`=1: capture `candidate` into `res_candidate`, set `res_tag`, `res_timeout`<=0, `res_valid`<=1, go to IDLE.
  - On timer == TIMEOUT-1 with `valid`=0: `res_candidate`<=0, `res_timeout`<=1, `res_valid`<=1, go to IDLE.
  - If both occur in the same cycle, `valid` wins.
- `res_valid` clears on `res_ready`, unless a new result loads in the same cycle, in which case the new result replaces the old one.
- `valid` seen in IDLE (late or spurious) is ignored.
- After a timeout, IDLE still waits for `busy`=0 before the next issue.
- Timer width is $clog2(TIMEOUT+1) bits; it saturates and never wraps.
- FIFO pointers are log2(DEPTH) bits plus one wrap bit, so wrap-around is seamless.

## Timing
- Reset (synchronous): state IDLE, FIFO empty, timer 0.
  - `en`, `central`, `radius`, `mode` = 0.
  - `res_valid`, `res_candidate`, `res_tag`, `res_timeout` = 0.
  - `cmd_ready`=1 and `idle`=1 from the first post-reset cycle.
- Reset in WAIT drops the in-flight command and all queued commands. The engine shares `rst`.
- Issue latency: command pushed at edge E, popped at E+1, `en` high during cycle E+1..E+2.
- Engine behaviour: samples `en` at E+2, runs 64 busy cycles, `valid` at E+66.
- `res_valid` rises the edge after `valid`.
- Back-to-back throughput with `res_ready`=1: the next `en` rises one cycle after `res_valid`, since `busy` is already low.

## Structure
- Package `set_pkg` holds:
  - `MODE_A`=2'd0, `MODE_AND`=2'd1, `MODE_XOR`=2'd2;
  - `CENTRAL_W`=24, `RADIUS_W`=12, `COUNT_W`=8;
  - the state enum {IDLE, WAIT};
  - a packed command struct {central, radius, mode, tag}.
- Sub-module `set_cmd_fifo`: synchronous FIFO of the command struct, parameterised by DEPTH, with full/empty flags.

## Test plan
- Single command: mode 0, central 24'h440000, radius 12'h200, behavioural `SET` model. Required: `en` high exactly one cycle, then `res_candidate`=13, `res_timeout`=0, `res_tag` echoed, `res_valid` 65 cycles after `en` plus one.
- Identical circles: central 24'h444400, radius 12'h220. Mode 1 → 13; mode 2 → 0.
- Burst: five commands with `res_ready`=1, tags 0..4. Required: `cmd_ready` drops while four entries are held, results return in tag order, and exactly one `en` is issued per command.
- Backpressure: `res_ready`=0 with two commands queued. Required: the second `en` is withheld until the first result is accepted, and `res_*` stays stable while held.
- Timeout: engine model ignores `en`, `busy` stays 0. Required: after 80 WAIT cycles, `res_valid`=1, `res_timeout`=1, `res_candidate`=0; a later stray `valid` is ignored.
- Reset mid-WAIT: `rst` pulsed 20 cycles after `en` with two commands queued. Required: all outputs 0, no `res_valid`, `idle`=1, `cmd_ready`=1 on the next cycle.
